// File: rtl/pong_game_ctrl.sv
// Pong game-logic stage: synchronises raw buttons, generates the move tick and owns
// paddle, ball, score and game-state registers read by the renderer and display logic.
module pong_game_ctrl #(
  parameter int unsigned TICK_BITS = 21,
  parameter int unsigned SCREEN_H  = 480,
  parameter int unsigned CENTER_X  = 320,
  parameter int unsigned CENTER_Y  = 240,
  parameter int unsigned P1_X      = 16,
  parameter int unsigned P2_X      = 623,
  parameter int unsigned PAD_HALF  = 32,
  parameter int unsigned PAD_STEP  = 4,
  parameter int unsigned BALL_DX   = 4,
  parameter int unsigned WIN_SCORE = 10
) (
  input  logic       board_clk,
  input  logic       reset,
  input  logic       start,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnL,
  input  logic       btnR,
  output logic [9:0] paddle1_y,
  output logic [9:0] paddle2_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] state,
  output logic       move_tick
);

  localparam int unsigned POS_W   = 10;
  localparam int unsigned SCORE_W = 4;
  localparam int unsigned CALC_W  = POS_W + 1;
  localparam int unsigned SYNC_W  = 5;

  localparam logic [1:0] QI      = 2'b00;
  localparam logic [1:0] QGAME_1 = 2'b01;
  localparam logic [1:0] QGAME_2 = 2'b10;
  localparam logic [1:0] QDONE   = 2'b11;

  localparam logic [POS_W-1:0]   CENTER_X_P = POS_W'(CENTER_X);
  localparam logic [POS_W-1:0]   CENTER_Y_P = POS_W'(CENTER_Y);
  localparam logic [POS_W-1:0]   Y_BOTTOM_P = POS_W'(SCREEN_H - 1);
  localparam logic [POS_W-1:0]   Y_REBOUND_P = POS_W'(SCREEN_H - 2);
  localparam logic [POS_W-1:0]   P1_RET_X_P = POS_W'(P1_X + 1);
  localparam logic [POS_W-1:0]   P2_RET_X_P = POS_W'(P2_X - 1);
  localparam logic [SCORE_W-1:0] WIN_P      = SCORE_W'(WIN_SCORE);

  localparam logic signed [CALC_W-1:0] P1_X_S     = CALC_W'(P1_X);
  localparam logic signed [CALC_W-1:0] P2_X_S     = CALC_W'(P2_X);
  localparam logic signed [CALC_W-1:0] PAD_HALF_S = CALC_W'(PAD_HALF);
  localparam logic signed [CALC_W-1:0] PAD_MAX_S  = CALC_W'(SCREEN_H - 1 - PAD_HALF);
  localparam logic signed [CALC_W-1:0] PAD_STEP_S = CALC_W'(PAD_STEP);
  localparam logic signed [CALC_W-1:0] BALL_DX_S  = CALC_W'(BALL_DX);

  // Two-flop synchronisers; bounce is masked by the slow tick.
  logic [SYNC_W-1:0] sync1_q, sync2_q;
  logic start_s, up1_s, dn1_s, up2_s, dn2_s;

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {start, btnU, btnD, btnL, btnR};
      sync2_q <= sync1_q;
    end
  end

  assign {start_s, up1_s, dn1_s, up2_s, dn2_s} = sync2_q;

  logic [TICK_BITS-1:0] tick_cnt_q;
  logic                 move_tick_q;

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      tick_cnt_q  <= '0;
      move_tick_q <= 1'b0;
    end else begin
      tick_cnt_q  <= tick_cnt_q + TICK_BITS'(1);
      move_tick_q <= &tick_cnt_q;
    end
  end

  logic [1:0]         state_q, state_d;
  logic [POS_W-1:0]   paddle1_y_q, paddle1_y_d;
  logic [POS_W-1:0]   paddle2_y_q, paddle2_y_d;
  logic [POS_W-1:0]   ball_x_q, ball_x_d;
  logic [POS_W-1:0]   ball_y_q, ball_y_d;
  logic               ball_down_q, ball_down_d;
  logic [SCORE_W-1:0] p1_score_q, p1_score_d;
  logic [SCORE_W-1:0] p2_score_q, p2_score_d;
  logic               clear_game;

  // Signed hit/miss arithmetic, always on the pre-move paddle positions.
  logic signed [CALC_W-1:0] bx_s, by_s, nx_left_s, nx_right_s;
  logic signed [CALC_W-1:0] dy1_s, dy2_s, dist1_s, dist2_s;
  logic                     hit_p1, hit_p2;

  assign bx_s       = $signed({1'b0, ball_x_q});
  assign by_s       = $signed({1'b0, ball_y_q});
  assign nx_left_s  = bx_s - BALL_DX_S;
  assign nx_right_s = bx_s + BALL_DX_S;
  assign dy1_s      = by_s - $signed({1'b0, paddle1_y_q});
  assign dy2_s      = by_s - $signed({1'b0, paddle2_y_q});
  assign dist1_s    = dy1_s[CALC_W-1] ? -dy1_s : dy1_s;
  assign dist2_s    = dy2_s[CALC_W-1] ? -dy2_s : dy2_s;
  assign hit_p1     = (dist1_s <= PAD_HALF_S);
  assign hit_p2     = (dist2_s <= PAD_HALF_S);

  function automatic logic [POS_W-1:0] paddle_step(input logic [POS_W-1:0] y,
                                                   input logic up, input logic dn);
    logic signed [CALC_W-1:0] t;
    t = $signed({1'b0, y});
    if (up && !dn) begin
      t = t - PAD_STEP_S;
      if (t < PAD_HALF_S) t = PAD_HALF_S;
    end else if (dn && !up) begin
      t = t + PAD_STEP_S;
      if (t > PAD_MAX_S) t = PAD_MAX_S;
    end
    return t[POS_W-1:0];
  endfunction

  always_comb begin
    state_d     = state_q;
    paddle1_y_d = paddle1_y_q;
    paddle2_y_d = paddle2_y_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    ball_down_d = ball_down_q;
    p1_score_d  = p1_score_q;
    p2_score_d  = p2_score_q;
    clear_game  = 1'b0;

    if (move_tick_q) begin
      case (state_q)
        QI: begin
          if (start_s) state_d = QGAME_2;
        end
        QGAME_1, QGAME_2: begin
          if (!start_s) begin
            clear_game = 1'b1;
          end else begin
            paddle1_y_d = paddle_step(paddle1_y_q, up1_s, dn1_s);
            paddle2_y_d = paddle_step(paddle2_y_q, up2_s, dn2_s);

            if (ball_down_q) begin
              if (ball_y_q == Y_BOTTOM_P) begin
                ball_down_d = 1'b0;
                ball_y_d    = Y_REBOUND_P;
              end else begin
                ball_y_d = ball_y_q + POS_W'(1);
              end
            end else if (ball_y_q == '0) begin
              ball_down_d = 1'b1;
              ball_y_d    = POS_W'(1);
            end else begin
              ball_y_d = ball_y_q - POS_W'(1);
            end

            // A miss recentres the ball over the vertical step just computed.
            if (state_q == QGAME_1) begin
              if (nx_left_s <= P1_X_S) begin
                if (hit_p1) begin
                  ball_x_d = P1_RET_X_P;
                  state_d  = QGAME_2;
                end else begin
                  ball_x_d = CENTER_X_P;
                  ball_y_d = CENTER_Y_P;
                  if (p2_score_q < WIN_P) p2_score_d = p2_score_q + SCORE_W'(1);
                  if (p2_score_d == WIN_P) state_d = QDONE;
                end
              end else begin
                ball_x_d = nx_left_s[POS_W-1:0];
              end
            end else begin
              if (nx_right_s >= P2_X_S) begin
                if (hit_p2) begin
                  ball_x_d = P2_RET_X_P;
                  state_d  = QGAME_1;
                end else begin
                  ball_x_d = CENTER_X_P;
                  ball_y_d = CENTER_Y_P;
                  if (p1_score_q < WIN_P) p1_score_d = p1_score_q + SCORE_W'(1);
                  if (p1_score_d == WIN_P) state_d = QDONE;
                end
              end else begin
                ball_x_d = nx_right_s[POS_W-1:0];
              end
            end
          end
        end
        default: begin
          if (!start_s) clear_game = 1'b1;
        end
      endcase
    end

    if (clear_game) begin
      state_d     = QI;
      paddle1_y_d = CENTER_Y_P;
      paddle2_y_d = CENTER_Y_P;
      ball_x_d    = CENTER_X_P;
      ball_y_d    = CENTER_Y_P;
      ball_down_d = 1'b1;
      p1_score_d  = '0;
      p2_score_d  = '0;
    end
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state_q     <= QI;
      paddle1_y_q <= CENTER_Y_P;
      paddle2_y_q <= CENTER_Y_P;
      ball_x_q    <= CENTER_X_P;
      ball_y_q    <= CENTER_Y_P;
      ball_down_q <= 1'b1;
      p1_score_q  <= '0;
      p2_score_q  <= '0;
    end else begin
      state_q     <= state_d;
      paddle1_y_q <= paddle1_y_d;
      paddle2_y_q <= paddle2_y_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      ball_down_q <= ball_down_d;
      p1_score_q  <= p1_score_d;
      p2_score_q  <= p2_score_d;
    end
  end

  assign paddle1_y = paddle1_y_q;
  assign paddle2_y = paddle2_y_q;
  assign ball_x    = ball_x_q;
  assign ball_y    = ball_y_q;
  assign p1_score  = p1_score_q;
  assign p2_score  = p2_score_q;
  assign state     = state_q;
  assign move_tick = move_tick_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: a game-level reference model, advanced once per move tick,
// is compared against every output on every falling clock edge.
`timescale 1ns/1ps
module tb_pong_game_ctrl;

  logic       board_clk = 1'b0;
  logic       reset     = 1'b1;
  logic       start     = 1'b0;
  logic       btnU = 1'b0, btnD = 1'b0, btnL = 1'b0, btnR = 1'b0;
  logic [9:0] paddle1_y, paddle2_y, ball_x, ball_y;
  logic [3:0] p1_score, p2_score;
  logic [1:0] state;
  logic       move_tick;

  pong_game_ctrl #(.TICK_BITS(2)) dut (
    .board_clk (board_clk),
    .reset     (reset),
    .start     (start),
    .btnU      (btnU),
    .btnD      (btnD),
    .btnL      (btnL),
    .btnR      (btnR),
    .paddle1_y (paddle1_y),
    .paddle2_y (paddle2_y),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .p1_score  (p1_score),
    .p2_score  (p2_score),
    .state     (state),
    .move_tick (move_tick)
  );

  always #5 board_clk = ~board_clk;

  int checks = 0;
  int errors = 0;

  // Game model: phase 0 idle, 1 playing, 2 done; vx/vy are +-1 directions.
  int m_p1, m_p2, m_bx, m_by, m_vx, m_vy, m_s1, m_s2, m_phase, m_edges;
  logic [4:0] m_in_d1, m_in_d2;
  int prev_state, prev_s1, prev_s2, p1_hits, p2_hits;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_game_reset();
    m_phase = 0; m_p1 = 240; m_p2 = 240; m_bx = 320; m_by = 240;
    m_vx = 1; m_vy = 1; m_s1 = 0; m_s2 = 0;
  endfunction

  function automatic void m_reset_all();
    m_game_reset();
    m_edges = 0; m_in_d1 = '0; m_in_d2 = '0;
    prev_state = 0; prev_s1 = 0; prev_s2 = 0;
  endfunction

  function automatic int pad_move(input int y, input bit up, input bit dn);
    if (up && !dn) return (y - 4 < 32) ? 32 : y - 4;
    if (dn && !up) return (y + 4 > 447) ? 447 : y + 4;
    return y;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int m_state_code();
    if (m_phase == 0) return 0;
    if (m_phase == 2) return 3;
    return (m_vx < 0) ? 1 : 2;
  endfunction

  function automatic void m_game_tick(input logic [4:0] in);
    bit st, u1, d1, u2, d2, crossed;
    int ny, nx, pad;
    {st, u1, d1, u2, d2} = in;
    if (m_phase == 0) begin
      if (st) begin m_phase = 1; m_vx = 1; end
    end else if (!st) begin
      m_game_reset();
    end else if (m_phase == 1) begin
      ny = m_by + m_vy;
      if (ny < 0) begin ny = 1; m_vy = 1; end
      else if (ny > 479) begin ny = 478; m_vy = -1; end
      nx      = m_bx + 4 * m_vx;
      pad     = (m_vx < 0) ? m_p1 : m_p2;
      crossed = (m_vx < 0) ? (nx <= 16) : (nx >= 623);
      if (!crossed) begin
        m_bx = nx;
      end else if (iabs(m_by - pad) <= 32) begin
        m_bx = (m_vx < 0) ? 17 : 622;
        m_vx = -m_vx;
      end else begin
        if (m_vx < 0) m_s2 = (m_s2 < 10) ? m_s2 + 1 : 10;
        else          m_s1 = (m_s1 < 10) ? m_s1 + 1 : 10;
        m_bx = 320;
        ny   = 240;
        if (m_s1 == 10 || m_s2 == 10) m_phase = 2;
      end
      m_by = ny;
      m_p1 = pad_move(m_p1, u1, d1);
      m_p2 = pad_move(m_p2, u2, d2);
    end
  endfunction

  // The game sees the buttons two edges late and acts on the edge after each tick pulse.
  always @(posedge board_clk) begin
    if (!reset) begin
      if (m_edges > 0 && m_edges % 4 == 0) m_game_tick(m_in_d2);
      m_in_d2 = m_in_d1;
      m_in_d1 = {start, btnU, btnD, btnL, btnR};
      m_edges++;
    end
  end

  always @(negedge board_clk) begin
    if (!reset) begin
      chk("state", int'(state), m_state_code());
      chk("paddle1_y", int'(paddle1_y), m_p1);
      chk("paddle2_y", int'(paddle2_y), m_p2);
      chk("ball_x", int'(ball_x), m_bx);
      chk("ball_y", int'(ball_y), m_by);
      chk("p1_score", int'(p1_score), m_s1);
      chk("p2_score", int'(p2_score), m_s2);
      chk("move_tick", int'(move_tick), (m_edges > 0 && m_edges % 4 == 0) ? 1 : 0);
      if (prev_state == 2 && state == 2'd1) begin
        chk("p2_return_x", int'(ball_x), 622);
        p2_hits++;
      end
      if (prev_state == 1 && state == 2'd2) begin
        chk("p1_return_x", int'(ball_x), 17);
        p1_hits++;
      end
      if (int'(p1_score) == prev_s1 + 1 || int'(p2_score) == prev_s2 + 1) begin
        chk("serve_x", int'(ball_x), 320);
        chk("serve_y", int'(ball_y), 240);
      end
      prev_state = int'(state);
      prev_s1    = int'(p1_score);
      prev_s2    = int'(p2_score);
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n * 4) @(negedge board_clk);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_state"}, int'(state), 0);
    chk({tag, "_ball_x"}, int'(ball_x), 320);
    chk({tag, "_ball_y"}, int'(ball_y), 240);
    chk({tag, "_pad1"}, int'(paddle1_y), 240);
    chk({tag, "_pad2"}, int'(paddle2_y), 240);
    chk({tag, "_score1"}, int'(p1_score), 0);
    chk({tag, "_score2"}, int'(p2_score), 0);
    chk({tag, "_tick"}, int'(move_tick), 0);
  endtask

  initial begin
    bit found;
    p1_hits = 0;
    p2_hits = 0;
    m_reset_all();
    repeat (3) @(negedge board_clk);
    chk_reset_values("por");
    #1 reset = 1'b0;

    // Serve: idle until start, then ball heads right at +4/+1 per tick.
    wait_ticks(3);
    chk("idle_hold_state", int'(state), 0);
    start = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge board_clk);
      if (state == 2'd2) found = 1'b1;
    end
    chk("serve_reached", int'(found), 1);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge board_clk);
      if (move_tick) found = 1'b1;
    end
    chk("tick_seen", int'(found), 1);
    @(negedge board_clk);
    chk("first_move_x", int'(ball_x), 324);
    chk("first_move_y", int'(ball_y), 241);

    // Paddle clamp and both-button hold.
    btnU = 1'b1;
    wait_ticks(70);
    chk("p1_top_clamp", int'(paddle1_y), 32);
    btnU = 1'b0; btnD = 1'b1;
    wait_ticks(20);
    btnU = 1'b1;
    wait_ticks(10);
    chk("p1_both_hold", int'(paddle1_y), 112);
    btnU = 1'b0; btnD = 1'b0;
    wait_ticks(2);
    chk("p1_none_hold", int'(paddle1_y), 112);

    // Long rally: both paddles chase the ball, covering hits and wall bounces.
    repeat (3600) begin
      @(negedge board_clk);
      btnU = (paddle1_y > ball_y + 2);
      btnD = (paddle1_y + 2 < ball_y);
      btnL = (paddle2_y > ball_y + 2);
      btnR = (paddle2_y + 2 < ball_y);
    end
    chk("p2_hits_seen", int'(p2_hits > 0), 1);
    chk("p1_hits_seen", int'(p1_hits > 0), 1);

    // Random buttons with occasional start drops.
    for (int t = 0; t < 300; t++) begin
      {btnU, btnD, btnL, btnR} = 4'($urandom);
      start = ($urandom_range(0, 19) != 0);
      repeat ($urandom_range(2, 8)) @(negedge board_clk);
    end

    // Drive P1 to a win: P2 paddle parked at the top misses every serve.
    start = 1'b0;
    {btnU, btnD, btnL, btnR} = 4'b0000;
    wait_ticks(3);
    chk("clear_state", int'(state), 0);
    chk("clear_score1", int'(p1_score), 0);
    chk("clear_score2", int'(p2_score), 0);
    btnL = 1'b1;
    start = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 5000 && !found; i++) begin
      @(negedge board_clk);
      if (state == 2'd3) found = 1'b1;
    end
    chk("done_reached", int'(found), 1);
    chk("win_score", int'(p1_score), 10);
    chk("loser_score", int'(p2_score), 0);
    for (int t = 0; t < 10; t++) begin
      {btnU, btnD, btnL, btnR} = 4'($urandom);
      wait_ticks(1);
    end
    chk("done_frozen_state", int'(state), 3);
    start = 1'b0;
    wait_ticks(3);
    chk("done_exit_state", int'(state), 0);
    chk("done_exit_score1", int'(p1_score), 0);
    chk("done_exit_ball_x", int'(ball_x), 320);

    // Asynchronous reset in mid-rally.
    start = 1'b1;
    for (int t = 0; t < 40; t++) begin
      {btnU, btnD, btnL, btnR} = 4'($urandom);
      wait_ticks(1);
    end
    @(negedge board_clk);
    #2 reset = 1'b1;
    m_reset_all();
    #1 chk_reset_values("async");
    @(negedge board_clk);
    #1 reset = 1'b0;
    wait_ticks(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
